// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
//   Shared widths, slot-phase constants and the per-port request record used
//   by the SDRAM slot arbiter and its round-robin picker.
//
//   Contents:
//     ADDR_W / DATA_W / BANK_W   SDRAM controller interface widths
//     S_ARB                      slot cycle at which arbitration is registered
//     S_DROP                     last slot cycle (strobes low) for the default
//                                16-cycle slot; slot_drop() for other lengths
//     port_req_t                 one requester's we/addr/bank/din bundle
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 8;
  localparam int BANK_W = 2;

  localparam int DEF_SLOT_CYCLES = 16;

  // Slot phases. Arbitration is sampled on the edge that ends s = S_ARB;
  // the last cycle of a slot always has both strobes low.
  localparam int S_ARB  = 0;
  localparam int S_DROP = DEF_SLOT_CYCLES - 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
    logic [DATA_W-1:0] din;
  } port_req_t;

  // Last slot cycle for an arbitrary slot length.
  function automatic int slot_drop(input int slot_cycles);
    return slot_cycles - 1;
  endfunction

endpackage

// File: rtl/sdram_slot_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Purely combinational round-robin pick. The search begins at start_port
//   and walks upward with wraparound; the first requesting port wins.
//
//   Ports:
//     req           in  NPORTS  candidate vector
//     start_port    in  IDX_W   first port examined (one past the last grant)
//     grant_onehot  out NPORTS  winner, one-hot (all zero when none)
//     grant_idx     out IDX_W   winner index (0 when none)
//     grant_valid   out 1       a winner exists
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NPORTS = 3,
  parameter int IDX_W  = 2
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  start_port,
  output logic [NPORTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  always_comb begin
    int p;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    p            = 0;
    for (int k = 0; k < NPORTS; k++) begin
      // Rotated index; start_port is always < NPORTS so one wrap suffices.
      p = int'(start_port) + k;
      if (p >= NPORTS) begin
        p = p - NPORTS;
      end
      if (!grant_valid && req[p]) begin
        grant_valid     = 1'b1;
        grant_onehot[p] = 1'b1;
        grant_idx       = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_slot_arbiter
//   Time-slot arbiter sharing one 8-bit SDRAM controller among NPORTS
//   requesters. Each slot is SLOT_CYCLES clocks long; at most one access is
//   granted per slot (round-robin), and every REFRESH_SLOTS-th slot is left
//   idle so the controller can run auto-refresh.
//
//   Ports:
//     clk, reset            system clock, synchronous active-high reset
//     ram_init              SDRAM initialising: no new grants while high
//     req/we                per-port request level and write flag
//     addr/bank/din         per-port packed address, bank and write data
//     ack                   per-port one-cycle completion pulse
//     dout                  read data, valid in the ack cycle, held after
//     mem_clkref            slot reference: high for the first half slot
//     mem_oe/mem_we         read/write strobes, high s = 1 .. SLOT_CYCLES-2
//     mem_addr/bank/din     access parameters, stable for the whole slot
//     mem_dout              read data from the controller
// ---------------------------------------------------------------------------
module sdram_slot_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS        = 3,
  parameter int SLOT_CYCLES   = 16,
  parameter int DATA_CYCLE    = 10,
  parameter int REFRESH_SLOTS = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ram_init,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*BANK_W-1:0] bank,
  input  logic [NPORTS*DATA_W-1:0] din,
  output logic [NPORTS-1:0]        ack,
  output logic [DATA_W-1:0]        dout,
  output logic                     mem_clkref,
  output logic                     mem_oe,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BANK_W-1:0]        mem_bank,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int REF_W = $clog2(REFRESH_SLOTS + 1);

  localparam logic [CNT_W-1:0] S_ARB_C    = CNT_W'(S_ARB);
  localparam logic [CNT_W-1:0] S_LAST_C   = CNT_W'(slot_drop(SLOT_CYCLES));
  // Strobes are cleared on the edge ending this cycle, so they read low
  // during the final slot cycle.
  localparam logic [CNT_W-1:0] S_OFF_C    = CNT_W'(slot_drop(SLOT_CYCLES) - 1);
  localparam logic [CNT_W-1:0] S_DATA_C   = CNT_W'(DATA_CYCLE);
  localparam logic [CNT_W-1:0] S_HALF_C   = CNT_W'(SLOT_CYCLES / 2);
  localparam logic [REF_W-1:0] REF_LAST_C = REF_W'(REFRESH_SLOTS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_C = IDX_W'(NPORTS - 1);

  // -------------------------------------------------------------------------
  // Per-port request records
  // -------------------------------------------------------------------------
  port_req_t port_req [NPORTS];

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_unpack
      assign port_req[gi] = '{
        we:   we[gi],
        addr: addr[gi*ADDR_W +: ADDR_W],
        bank: bank[gi*BANK_W +: BANK_W],
        din:  din[gi*DATA_W +: DATA_W]
      };
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]  s_reg, s_next;
  logic [REF_W-1:0]  ref_reg, ref_next;
  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;      // first port searched
  logic              active_reg, active_next;      // slot carries an access
  logic [NPORTS-1:0] win_onehot_reg, win_onehot_next;
  logic              win_we_reg, win_we_next;
  logic              clkref_reg, clkref_next;
  logic              mem_oe_reg, mem_oe_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [BANK_W-1:0] mem_bank_reg, mem_bank_next;
  logic [DATA_W-1:0] mem_din_reg, mem_din_next;
  logic [NPORTS-1:0] ack_reg, ack_next;
  logic [DATA_W-1:0] dout_reg, dout_next;

  // -------------------------------------------------------------------------
  // Round-robin pick over the live request vector
  // -------------------------------------------------------------------------
  logic [NPORTS-1:0] pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  port_req_t         win_req;

  rr_picker #(
    .NPORTS (NPORTS),
    .IDX_W  (IDX_W)
  ) u_rr_picker (
    .req          (req),
    .start_port   (rr_ptr_reg),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .grant_valid  (pick_valid)
  );

  // One-hot mux of the winning port's record.
  always_comb begin
    win_req = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (pick_onehot[k]) begin
        win_req = port_req[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic is_arb;
  logic refresh_slot;
  logic grant;

  always_comb begin
    s_next          = (s_reg == S_LAST_C) ? '0 : s_reg + 1'b1;
    clkref_next     = (s_next < S_HALF_C);

    is_arb          = (s_reg == S_ARB_C);
    refresh_slot    = (ref_reg == REF_LAST_C);
    grant           = is_arb && pick_valid && !ram_init && !refresh_slot;

    ref_next        = ref_reg;
    rr_ptr_next     = rr_ptr_reg;
    active_next     = active_reg;
    win_onehot_next = win_onehot_reg;
    win_we_next     = win_we_reg;
    mem_oe_next     = mem_oe_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_bank_next   = mem_bank_reg;
    mem_din_next    = mem_din_reg;
    ack_next        = '0;
    dout_next       = dout_reg;

    if (is_arb) begin
      // The refresh counter advances once per slot whether or not the slot
      // is granted; the idle slot itself restarts it.
      ref_next    = refresh_slot ? '0 : ref_reg + 1'b1;
      active_next = grant;
      if (grant) begin
        win_onehot_next = pick_onehot;
        win_we_next     = win_req.we;
        mem_oe_next     = ~win_req.we;
        mem_we_next     = win_req.we;
        mem_addr_next   = win_req.addr;
        mem_bank_next   = win_req.bank;
        mem_din_next    = win_req.din;
        rr_ptr_next     = (pick_idx == IDX_LAST_C) ? '0 : pick_idx + 1'b1;
      end
    end

    if (s_reg == S_OFF_C) begin
      mem_oe_next = 1'b0;
      mem_we_next = 1'b0;
    end

    // Read data is captured together with the ack so both appear in the
    // same cycle; the access completes even if req or ram_init changed.
    if ((s_reg == S_DATA_C) && active_reg) begin
      ack_next = win_onehot_reg;
      if (!win_we_reg) begin
        dout_next = mem_dout;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg          <= '0;
      ref_reg        <= '0;
      rr_ptr_reg     <= '0;
      active_reg     <= 1'b0;
      win_onehot_reg <= '0;
      win_we_reg     <= 1'b0;
      clkref_reg     <= 1'b0;
      mem_oe_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_bank_reg   <= '0;
      mem_din_reg    <= '0;
      ack_reg        <= '0;
      dout_reg       <= '0;
    end else begin
      s_reg          <= s_next;
      ref_reg        <= ref_next;
      rr_ptr_reg     <= rr_ptr_next;
      active_reg     <= active_next;
      win_onehot_reg <= win_onehot_next;
      win_we_reg     <= win_we_next;
      clkref_reg     <= clkref_next;
      mem_oe_reg     <= mem_oe_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_bank_reg   <= mem_bank_next;
      mem_din_reg    <= mem_din_next;
      ack_reg        <= ack_next;
      dout_reg       <= dout_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ack        = ack_reg;
  assign dout       = dout_reg;
  assign mem_clkref = clkref_reg;
  assign mem_oe     = mem_oe_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_bank   = mem_bank_reg;
  assign mem_din    = mem_din_reg;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_slot_arbiter
//   Directed stimulus with a scoreboard: each expected ack (port, dout) is
//   queued when the request is issued; a negedge monitor pops and compares
//   whenever ack pulses, and also logs the controller strobes per slot.
// ---------------------------------------------------------------------------
module tb_sdram_slot_arbiter;
  import sdram_arb_pkg::*;

  localparam int NP = 3;
  localparam int SC = 16;
  localparam int DC = 10;
  localparam int RS = 64;
  localparam int NLOG = 160;

  logic              clk = 1'b0;
  logic              reset;
  logic              ram_init;
  logic [NP-1:0]     req;
  logic [NP-1:0]     we;
  logic [NP*23-1:0]  addr;
  logic [NP*2-1:0]   bank;
  logic [NP*8-1:0]   din;
  logic [NP-1:0]     ack;
  logic [7:0]        dout;
  logic              mem_clkref;
  logic              mem_oe;
  logic              mem_we;
  logic [22:0]       mem_addr;
  logic [1:0]        mem_bank;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;

  always #5 clk = ~clk;

  // Controller read model: data = low address byte + 0x60 while oe is high.
  assign mem_dout = mem_oe ? (mem_addr[7:0] + 8'h60) : 8'h00;

  sdram_slot_arbiter #(
    .NPORTS        (NP),
    .SLOT_CYCLES   (SC),
    .DATA_CYCLE    (DC),
    .REFRESH_SLOTS (RS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ram_init   (ram_init),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .bank       (bank),
    .din        (din),
    .ack        (ack),
    .dout       (dout),
    .mem_clkref (mem_clkref),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_bank   (mem_bank),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   ack_count = 0;

  // Contention sequence: p0 write, p1 read (0x70), p2 read (0x80).
  int         t3_port [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  logic [7:0] t3_data [9] = '{8'h00, 8'h70, 8'h80, 8'h80, 8'h70,
                              8'h80, 8'h80, 8'h70, 8'h80};

  // Per-slot log of controller activity.
  int          oe_cnt   [NLOG];
  int          we_cnt   [NLOG];
  int          edge_bad [NLOG];
  logic [22:0] addr_log [NLOG];
  logic [1:0]  bank_log [NLOG];
  logic [7:0]  din_log  [NLOG];
  logic        clk_s0   [NLOG];
  logic        clk_s8   [NLOG];

  // Bench slot position: cycle 0 is the first cycle after reset.
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic [7:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic set_port(input int p, input logic w, input logic [22:0] a,
                          input logic [1:0] b, input logic [7:0] d);
    we[p]          = w;
    addr[p*23 +: 23] = a;
    bank[p*2 +: 2]   = b;
    din[p*8 +: 8]    = d;
  endtask

  task automatic std_ports();
    set_port(0, 1'b1, 23'h000030, 2'd0, 8'h11);
    set_port(1, 1'b0, 23'h000010, 2'd1, 8'h00);
    set_port(2, 1'b0, 23'h000020, 2'd2, 8'h00);
  endtask

  task automatic wait_acks(input int target, input int max_cyc, input string name);
    int n;
    n = 0;
    while (ack_count < target && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (ack_count < target) begin
      errors++;
      $display("FAIL %s timeout acks=%0d required=%0d", name, ack_count, target);
    end
  endtask

  // Monitor: scoreboard pop on ack, per-slot strobe logging.
  always @(negedge clk) begin
    int   s;
    int   slot;
    exp_t e;
    s    = cyc % SC;
    slot = cyc / SC;
    if (slot < NLOG) begin
      if (s == 0) begin
        oe_cnt[slot]   = 0;
        we_cnt[slot]   = 0;
        edge_bad[slot] = 0;
        clk_s0[slot]   = mem_clkref;
      end
      if (mem_oe) oe_cnt[slot]++;
      if (mem_we) we_cnt[slot]++;
      if ((s == 0 || s == SC - 1) && (mem_oe || mem_we)) edge_bad[slot]++;
      if (s == 5) begin
        addr_log[slot] = mem_addr;
        bank_log[slot] = mem_bank;
        din_log[slot]  = mem_din;
      end
      if (s == 8) clk_s8[slot] = mem_clkref;
    end
    if (ack != '0) begin
      ack_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=%0h required=none", ack);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", 32'(ack), 32'(1) << e.port);
        check("ack_phase", 32'(s), 32'(DC + 1));
        check("ack_dout", 32'(dout), 32'(e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset    = 1'b1;
    ram_init = 1'b0;
    req      = '0;
    we       = '0;
    addr     = '0;
    bank     = '0;
    din      = '0;

    // ---- Reset state + single read by port 1 ----
    set_port(1, 1'b0, 23'h012345, 2'd1, 8'h00);
    req[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_clkref", 32'(mem_clkref), 32'h0);
    check("rst_oe_we", 32'({mem_oe, mem_we}), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    base = ack_count;
    push_exp(1, 8'hA5);
    wait_acks(base + 1, 40, "single_read");
    req[1] = 1'b0;

    // ---- Single write by port 0 (slot 1); dout keeps 0xA5 ----
    set_port(0, 1'b1, 23'h000001, 2'd2, 8'h3C);
    req[0] = 1'b1;
    push_exp(0, 8'hA5);
    wait_acks(base + 2, 40, "single_write");
    req[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("rd_oe_cnt", 32'(oe_cnt[0]), 32'd14);
    check("rd_we_cnt", 32'(we_cnt[0]), 32'd0);
    check("rd_edges", 32'(edge_bad[0]), 32'd0);
    check("rd_addr", 32'(addr_log[0]), 32'h012345);
    check("rd_bank", 32'(bank_log[0]), 32'd1);
    check("wr_we_cnt", 32'(we_cnt[1]), 32'd14);
    check("wr_oe_cnt", 32'(oe_cnt[1]), 32'd0);
    check("wr_edges", 32'(edge_bad[1]), 32'd0);
    check("wr_din", 32'(din_log[1]), 32'h3C);
    check("wr_addr", 32'(addr_log[1]), 32'h000001);
    check("clkref_s0", 32'(clk_s0[1]), 32'd1);
    check("clkref_s8", 32'(clk_s8[1]), 32'd0);
    check("wr_dout_kept", 32'(dout), 32'hA5);

    // ---- Contention: all ports from reset, order 0,1,2 repeating ----
    @(negedge clk);
    reset = 1'b1;
    std_ports();
    req = 3'b111;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = ack_count;
    for (int i = 0; i < 9; i++) push_exp(t3_port[i], t3_data[i]);
    wait_acks(base + 9, 9 * SC + 20, "contention");
    req = '0;
    repeat (8) @(negedge clk);
    check("cont_we_slot0", 32'(we_cnt[0]), 32'd14);
    check("cont_oe_slot1", 32'(oe_cnt[1]), 32'd14);
    check("cont_addr_slot2", 32'(addr_log[2]), 32'h000020);

    // ---- Refresh: 130 slots of continuous requests, slots 63/127 idle ----
    reset = 1'b1;
    std_ports();
    req = 3'b111;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = ack_count;
    for (int i = 0; i < 128; i++) begin
      if (i % 3 == 1)      push_exp(1, 8'h70);
      else if (i % 3 == 2) push_exp(2, 8'h80);
      else                 push_exp(0, (i == 0) ? 8'h00 : 8'h80);
    end
    wait_acks(base + 128, 131 * SC, "refresh");
    req = '0;
    repeat (8) @(negedge clk);
    check("ref_idle_63", 32'(oe_cnt[63] + we_cnt[63]), 32'd0);
    check("ref_idle_127", 32'(oe_cnt[127] + we_cnt[127]), 32'd0);
    check("ref_busy_62", 32'(oe_cnt[62] + we_cnt[62]), 32'd14);
    check("ref_busy_64", 32'(oe_cnt[64] + we_cnt[64]), 32'd14);
    check("ref_busy_128", 32'(oe_cnt[128] + we_cnt[128]), 32'd14);
    repeat (SC) @(negedge clk);
    check("ref_total_acks", 32'(ack_count - base), 32'd128);

    // ---- Init hold: 5 slots with ram_init, then port 0 first ----
    reset = 1'b1;
    ram_init = 1'b1;
    std_ports();
    req = 3'b111;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = ack_count;
    repeat (5 * SC) @(negedge clk);
    check("init_no_ack", 32'(ack_count - base), 32'd0);
    begin
      int sum;
      sum = 0;
      for (int k = 0; k < 5; k++) sum += oe_cnt[k] + we_cnt[k];
      check("init_no_strobe", 32'(sum), 32'd0);
    end
    ram_init = 1'b0;
    push_exp(0, 8'h00);
    wait_acks(base + 1, 40, "init_release");
    req = '0;
    repeat (8) @(negedge clk);

    // ---- Reset mid-access of a port 2 read ----
    reset = 1'b1;
    std_ports();
    req = 3'b100;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = ack_count;
    repeat (6) @(negedge clk);
    check("mid_oe_before", 32'(mem_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_oe_we", 32'({mem_oe, mem_we}), 32'h0);
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_addr", 32'(mem_addr), 32'h0);
    check("mid_rst_clkref", 32'(mem_clkref), 32'h0);
    reset = 1'b0;
    push_exp(2, 8'h80);
    wait_acks(base + 1, 40, "mid_reset_regrant");
    req = '0;
    repeat (2 * SC) @(negedge clk);
    check("mid_single_ack", 32'(ack_count - base), 32'd1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
